// File: rtl/kernel_loader_pkg.sv
// Shared types and defaults for the kernel loader: FSM state encoding and tap-count helper.
package kernel_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFinish
  } state_e;

  localparam int unsigned DefBitDepth   = 8;
  localparam int unsigned DefKernelSize = 3;

  function automatic int unsigned num_taps(input int unsigned kernel_size);
    return kernel_size * kernel_size;
  endfunction

endpackage

// File: rtl/kernel_loader_weight_skid_reg.sv
// One-entry skid register that parks a returning weight while the consumer is stalled.
module kernel_loader_weight_skid_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             capture_i,
  input  logic             drain_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (capture_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/kernel_loader.sv
// Fetches one kernel's taps from the weight SRAM and streams them to the kernel register,
// honouring consumer stalls through a one-entry skid.
module kernel_loader
  import kernel_loader_pkg::*;
#(
  parameter int unsigned BIT_DEPTH   = DefBitDepth,
  parameter int unsigned KERNEL_SIZE = DefKernelSize,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned KIDX_WIDTH  = 4,
  parameter int unsigned BASE_ADDR   = 0,
  parameter bit          REVERSE     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [KIDX_WIDTH-1:0] kernel_idx_i,
  input  logic                  hold_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [BIT_DEPTH-1:0]  mem_rd_data_i,
  output logic [BIT_DEPTH-1:0]  kernel_out_o,
  output logic                  kernel_wr_en_o
);

  localparam int unsigned N    = num_taps(KERNEL_SIZE);
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] NCnt    = CntW'(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       issued_q, issued_d;
  logic [CntW-1:0]       written_q, written_d;
  logic                  pending_q;
  logic [KIDX_WIDTH-1:0] kidx_q, kidx_d;
  logic [BIT_DEPTH-1:0]  kout_q;

  logic                  skid_valid, skid_capture, skid_drain;
  logic [BIT_DEPTH-1:0]  skid_data;
  logic [CntW-1:0]       tap;
  logic [ADDR_WIDTH-1:0] tap_addr;
  logic                  rd_en, wr_en;
  logic [BIT_DEPTH-1:0]  wr_data;

  kernel_loader_weight_skid_reg #(
    .Width(BIT_DEPTH)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .capture_i(skid_capture),
    .drain_i  (skid_drain),
    .data_i   (mem_rd_data_i),
    .valid_o  (skid_valid),
    .data_o   (skid_data)
  );

  // Address arithmetic deliberately truncated to ADDR_WIDTH so it wraps around the SRAM.
  always_comb begin
    tap      = REVERSE ? (LastCnt - issued_q) : issued_q;
    tap_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(kidx_q) * ADDR_WIDTH'(N)
             + ADDR_WIDTH'(tap);
  end

  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    written_d    = written_q;
    kidx_d       = kidx_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = kout_q;
    skid_capture = 1'b0;
    skid_drain   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StLoad;
          kidx_d    = kernel_idx_i;
          issued_d  = '0;
          written_d = '0;
        end
      end
      StLoad: begin
        rd_en = !hold_i && !skid_valid && (issued_q < NCnt);
        if (!hold_i) begin
          // A parked weight is older than anything in flight, so it goes first.
          if (skid_valid) begin
            wr_en      = 1'b1;
            wr_data    = skid_data;
            skid_drain = 1'b1;
          end else if (pending_q) begin
            wr_en   = 1'b1;
            wr_data = mem_rd_data_i;
          end
        end else begin
          skid_capture = pending_q;
        end
        if (rd_en) issued_d = issued_q + CntW'(1);
        if (wr_en) begin
          written_d = written_q + CntW'(1);
          if (written_q == LastCnt) state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      issued_q  <= '0;
      written_q <= '0;
      pending_q <= 1'b0;
      kidx_q    <= '0;
      kout_q    <= '0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      written_q <= written_d;
      pending_q <= rd_en;
      kidx_q    <= kidx_d;
      kout_q    <= wr_data;
    end
  end

  assign busy_o         = (state_q == StLoad);
  assign done_o         = (state_q == StFinish);
  assign mem_rd_en_o    = rd_en;
  assign mem_addr_o     = rd_en ? tap_addr : '0;
  assign kernel_wr_en_o = wr_en;
  assign kernel_out_o   = wr_data;

endmodule

// File: tb/tb_kernel_loader.sv
// Directed bench for kernel_loader: a default instance and a narrow-address forward instance.
module tb_kernel_loader;

  localparam int N = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] kidx = '0;

  logic       busy_a, done_a, rd_a, wr_a;
  logic [9:0] addr_a;
  logic [7:0] rdata_a = '0, kout_a;
  logic       busy_b, done_b, rd_b, wr_b;
  logic [4:0] addr_b;
  logic [7:0] rdata_b = '0, kout_b;

  kernel_loader u_dut_a (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start_a),
    .kernel_idx_i  (kidx),
    .hold_i        (hold),
    .busy_o        (busy_a),
    .done_o        (done_a),
    .mem_rd_en_o   (rd_a),
    .mem_addr_o    (addr_a),
    .mem_rd_data_i (rdata_a),
    .kernel_out_o  (kout_a),
    .kernel_wr_en_o(wr_a)
  );

  kernel_loader #(
    .ADDR_WIDTH(5),
    .REVERSE   (1'b0)
  ) u_dut_b (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start_b),
    .kernel_idx_i  (kidx),
    .hold_i        (hold),
    .busy_o        (busy_b),
    .done_o        (done_b),
    .mem_rd_en_o   (rd_b),
    .mem_addr_o    (addr_b),
    .mem_rd_data_i (rdata_b),
    .kernel_out_o  (kout_b),
    .kernel_wr_en_o(wr_b)
  );

  // SRAM model: every location holds its own address.
  always @(posedge clk) begin
    if (rd_a) rdata_a <= 8'(addr_a);
    if (rd_b) rdata_b <= {3'b000, addr_b};
  end

  bit         sel = 1'b0;
  logic       busy, done, rd, wr;
  logic [9:0] addr;
  logic [7:0] kout;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign rd   = sel ? rd_b : rd_a;
  assign wr   = sel ? wr_b : wr_a;
  assign addr = sel ? {5'b00000, addr_b} : addr_a;
  assign kout = sel ? kout_b : kout_a;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_addr(input bit b_sel, input logic [3:0] k_idx, input int k);
    int base;
    base = int'(k_idx) * N;
    if (!b_sel) return (base + (N - 1 - k)) % 1024;
    return (base + k) % 32;
  endfunction

  typedef struct {
    string       name;
    bit          sel;
    logic [3:0]  kidx;
    logic [63:0] hmask;
    logic [63:0] smask;
    int          exp_first_wr;
    int          exp_done;
  } vec_t;

  task automatic apply(input vec_t v);
    int rcnt = 0, wcnt = 0, ndone = 0, done_cyc = -1, first_wr = -1, last_wr = -1;
    int busy_first = -1, busy_last = -1, busy_cnt = 0, viol = 0;
    sel = v.sel;
    @(posedge clk);
    #1;
    kidx    = v.kidx;
    start_a = !v.sel;
    start_b = v.sel;
    hold    = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        start_a = !v.sel && v.smask[c];
        start_b = v.sel && v.smask[c];
        hold    = v.hmask[c];
      end
      @(negedge clk);
      if (rd) begin
        if (rcnt < N) check({v.name, ".rd_addr"}, int'(addr), exp_addr(v.sel, v.kidx, rcnt));
        rcnt++;
      end
      if (wr) begin
        if (hold) viol++;
        if (wcnt < N) check({v.name, ".wr_data"}, int'(kout), exp_addr(v.sel, v.kidx, wcnt) % 256);
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        wcnt++;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        busy_cnt++;
      end
      if (done) begin
        ndone++;
        done_cyc = c;
      end
    end
    hold = 1'b0;
    check({v.name, ".reads"}, rcnt, N);
    check({v.name, ".writes"}, wcnt, N);
    check({v.name, ".wr_during_hold"}, viol, 0);
    check({v.name, ".done_pulses"}, ndone, 1);
    check({v.name, ".done_after_last_wr"}, done_cyc, last_wr + 1);
    check({v.name, ".busy_first"}, busy_first, 1);
    check({v.name, ".busy_last"}, busy_last, done_cyc - 1);
    check({v.name, ".busy_cycles"}, busy_cnt, done_cyc - 1);
    check({v.name, ".kout_held"}, int'(kout), exp_addr(v.sel, v.kidx, N - 1) % 256);
    if (v.exp_first_wr >= 0) check({v.name, ".first_wr"}, first_wr, v.exp_first_wr);
    if (v.exp_done >= 0) check({v.name, ".done_cycle"}, done_cyc, v.exp_done);
  endtask

  vec_t vecs[6];

  initial begin
    int nz, pre_wr;
    vecs[0] = '{name: "rev_k2", sel: 1'b0, kidx: 4'd2, hmask: 64'h0, smask: 64'h1,
                exp_first_wr: 2, exp_done: 11};
    vecs[1] = '{name: "hold_4_6", sel: 1'b0, kidx: 4'd2, hmask: 64'h70, smask: 64'h1,
                exp_first_wr: 2, exp_done: -1};
    vecs[2] = '{name: "hold_toggle", sel: 1'b0, kidx: 4'd2,
                hmask: 64'hAAAA_AAAA_AAAA_AAAA, smask: 64'h1, exp_first_wr: -1, exp_done: -1};
    vecs[3] = '{name: "fwd_wrap_k3", sel: 1'b1, kidx: 4'd3, hmask: 64'h0, smask: 64'h1,
                exp_first_wr: 2, exp_done: 11};
    vecs[4] = '{name: "start_ignored", sel: 1'b0, kidx: 4'd2, hmask: 64'h0, smask: 64'h809,
                exp_first_wr: 2, exp_done: 11};
    vecs[5] = '{name: "rev_k15", sel: 1'b0, kidx: 4'd15, hmask: 64'h0, smask: 64'h1,
                exp_first_wr: 2, exp_done: 11};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", int'(busy_a), 0);
    check("reset.done", int'(done_a), 0);
    check("reset.rd_en", int'(rd_a), 0);
    check("reset.wr_en", int'(wr_a), 0);
    check("reset.addr", int'(addr_a), 0);
    check("reset.kout", int'(kout_a), 0);
    check("reset.b_any", int'(busy_b | done_b | rd_b | wr_b | (|addr_b) | (|kout_b)), 0);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) apply(vecs[i]);

    // Abort a load with a one-cycle reset in cycle 5.
    sel = 1'b0;
    nz = 0;
    pre_wr = 0;
    @(posedge clk);
    #1;
    kidx    = 4'd2;
    start_a = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      rst     = (c == 5);
      @(negedge clk);
      if (c <= 5 && wr) pre_wr++;
      if (c >= 6 && (busy || done || rd || wr || addr != 0 || kout != 0)) nz++;
    end
    check("abort.writes_before_rst", pre_wr, 4);
    check("abort.outputs_zero", nz, 0);

    apply(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
